// File: rtl/rv.sv
// Shared CSR definitions: machine-mode addresses, CSR op encoding and mstatus bit positions.
package rv;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    typedef enum logic [1:0] {
        CSR_RW  = 2'd0,
        CSR_RS  = 2'd1,
        CSR_RC  = 2'd2,
        CSR_NOP = 2'd3
    } csr_op_t;

    function automatic logic csr_implemented(input logic [11:0] a);
        case (a)
            CSR_MSTATUS, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE,
            CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH,
            CSR_CYCLE, CSR_CYCLEH, CSR_INSTRET, CSR_INSTRETH: csr_implemented = 1'b1;
            default: csr_implemented = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// Free-running counter with independently writable 32-bit low and upper halves.
module csr_counter64 #(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             wr_lo,
    input  logic             wr_hi,
    input  logic [31:0]      wdata,
    output logic [CNT_W-1:0] value
);

    logic [CNT_W-1:0] value_q, value_d;

    // A half write holds the other half and swallows this cycle's increment.
    always_comb begin
        value_d = value_q;
        if (wr_lo) begin
            value_d[31:0] = wdata;
        end else if (wr_hi) begin
            value_d[CNT_W-1:32] = wdata[CNT_W-33:0];
        end else if (inc) begin
            value_d = value_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/core_csr_writer.sv
// Machine-mode CSR write side: commits writeback CSR ops, trap/mret updates, and
// serves the decode read port with same-cycle write bypass.
module core_csr_writer
    import rv::*;
#(
    parameter int CNT_W = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_valid,
    input  logic [11:0] wr_addr,
    input  logic [1:0]  wr_op,
    input  logic [31:0] wr_src,
    output logic [31:0] wr_old,
    output logic        wr_illegal,
    input  logic        retire,
    input  logic        trap_valid,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_pc,
    input  logic        mret_valid,
    input  logic [11:0] rd_addr,
    output logic [31:0] rd_value,
    output logic [31:0] mtvec_o,
    output logic [31:0] mepc_o,
    output logic        mie_o
);

    logic        mie_q, mie_d, mpie_q, mpie_d;
    logic [31:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d, mcause_q, mcause_d;

    logic [CNT_W-1:0] mcycle, minstret;
    logic [31:0]      mcycle_hi, minstret_hi;
    logic [31:0]      new_val, fwd_val;
    logic             wr_en, commit;
    csr_op_t          op;

    assign op = csr_op_t'(wr_op);

    always_comb begin
        mcycle_hi                = '0;
        minstret_hi              = '0;
        mcycle_hi[CNT_W-33:0]    = mcycle[CNT_W-1:32];
        minstret_hi[CNT_W-33:0]  = minstret[CNT_W-1:32];
    end

    // Old-value mux shared by wr_old and the non-bypassed read path.
    function automatic logic [31:0] csr_mux(input logic [11:0] a);
        logic [31:0] v;
        v = '0;
        case (a)
            CSR_MSTATUS: begin
                v[MSTATUS_MIE]  = mie_q;
                v[MSTATUS_MPIE] = mpie_q;
            end
            CSR_MTVEC:                   v = mtvec_q;
            CSR_MSCRATCH:                v = mscratch_q;
            CSR_MEPC:                    v = mepc_q;
            CSR_MCAUSE:                  v = mcause_q;
            CSR_MCYCLE,   CSR_CYCLE:     v = mcycle[31:0];
            CSR_MCYCLEH,  CSR_CYCLEH:    v = mcycle_hi;
            CSR_MINSTRET, CSR_INSTRET:   v = minstret[31:0];
            CSR_MINSTRETH, CSR_INSTRETH: v = minstret_hi;
            default:                     v = '0;
        endcase
        return v;
    endfunction

    always_comb begin
        wr_old     = csr_mux(wr_addr);
        wr_illegal = wr_valid & ((wr_addr[11:10] == 2'b11) | ~csr_implemented(wr_addr));
        case (op)
            CSR_RW:  new_val = wr_src;
            CSR_RS:  new_val = wr_old | wr_src;
            CSR_RC:  new_val = wr_old & ~wr_src;
            default: new_val = wr_old;
        endcase
        wr_en  = wr_valid & ~wr_illegal & ~trap_valid & ~mret_valid;
        commit = wr_en & (op != CSR_NOP) & ~rst;
        // Forward exactly what the register would hold after the write.
        case (wr_addr)
            CSR_MSTATUS:         fwd_val = new_val & 32'h0000_0088;
            CSR_MTVEC, CSR_MEPC: fwd_val = new_val & ~32'h3;
            default:             fwd_val = new_val;
        endcase
        rd_value = (wr_en && (rd_addr == wr_addr)) ? fwd_val : csr_mux(rd_addr);
    end

    always_comb begin
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        if (trap_valid) begin
            mepc_d   = trap_pc & ~32'h3;
            mcause_d = trap_cause;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end else if (mret_valid) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end else if (commit) begin
            case (wr_addr)
                CSR_MSTATUS: begin
                    mie_d  = new_val[MSTATUS_MIE];
                    mpie_d = new_val[MSTATUS_MPIE];
                end
                CSR_MTVEC:    mtvec_d    = new_val & ~32'h3;
                CSR_MSCRATCH: mscratch_d = new_val;
                CSR_MEPC:     mepc_d     = new_val & ~32'h3;
                CSR_MCAUSE:   mcause_d   = new_val;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtvec_q    <= '0;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
        end else begin
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
        end
    end

    csr_counter64 #(.CNT_W(CNT_W)) u_mcycle (
        .clk   (clk),
        .rst   (rst),
        .inc   (1'b1),
        .wr_lo (commit && (wr_addr == CSR_MCYCLE)),
        .wr_hi (commit && (wr_addr == CSR_MCYCLEH)),
        .wdata (new_val),
        .value (mcycle)
    );

    csr_counter64 #(.CNT_W(CNT_W)) u_minstret (
        .clk   (clk),
        .rst   (rst),
        .inc   (retire),
        .wr_lo (commit && (wr_addr == CSR_MINSTRET)),
        .wr_hi (commit && (wr_addr == CSR_MINSTRETH)),
        .wdata (new_val),
        .value (minstret)
    );

    assign mtvec_o = mtvec_q;
    assign mepc_o  = mepc_q;
    assign mie_o   = mie_q;

endmodule

// File: tb/tb_core_csr_writer.sv
// Self-checking bench for core_csr_writer: directed cases plus randomized traffic
// against an architectural model of the CSR file.
module tb_core_csr_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_valid;
    logic [11:0] wr_addr;
    logic [1:0]  wr_op;
    logic [31:0] wr_src;
    logic [31:0] wr_old;
    logic        wr_illegal;
    logic        retire;
    logic        trap_valid;
    logic [31:0] trap_cause;
    logic [31:0] trap_pc;
    logic        mret_valid;
    logic [11:0] rd_addr;
    logic [31:0] rd_value;
    logic [31:0] mtvec_o;
    logic [31:0] mepc_o;
    logic        mie_o;

    int checks   = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;

    core_csr_writer #(.CNT_W(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_addr    (wr_addr),
        .wr_op      (wr_op),
        .wr_src     (wr_src),
        .wr_old     (wr_old),
        .wr_illegal (wr_illegal),
        .retire     (retire),
        .trap_valid (trap_valid),
        .trap_cause (trap_cause),
        .trap_pc    (trap_pc),
        .mret_valid (mret_valid),
        .rd_addr    (rd_addr),
        .rd_value   (rd_value),
        .mtvec_o    (mtvec_o),
        .mepc_o     (mepc_o),
        .mie_o      (mie_o)
    );

    // Architectural model state
    bit              m_mie, m_mpie;
    logic [31:0]     m_mtvec, m_mscratch, m_mepc, m_mcause;
    longint unsigned m_cyc, m_ins;

    function automatic bit m_impl(input logic [11:0] a);
        logic [11:0] list [13] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342,
                                   12'hB00, 12'hB80, 12'hB02, 12'hB82,
                                   12'hC00, 12'hC80, 12'hC02, 12'hC82};
        foreach (list[i]) if (list[i] == a) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300:          return (m_mie ? 32'h8 : 32'h0) + (m_mpie ? 32'h80 : 32'h0);
            12'h305:          return m_mtvec;
            12'h340:          return m_mscratch;
            12'h341:          return m_mepc;
            12'h342:          return m_mcause;
            12'hB00, 12'hC00: return m_cyc[31:0];
            12'hB80, 12'hC80: return m_cyc[63:32];
            12'hB02, 12'hC02: return m_ins[31:0];
            12'hB82, 12'hC82: return m_ins[63:32];
            default:          return 32'h0;
        endcase
    endfunction

    function automatic bit m_illegal();
        return wr_valid && ((wr_addr >= 12'hC00) || !m_impl(wr_addr));
    endfunction

    function automatic logic [31:0] m_new();
        logic [31:0] o;
        o = m_read(wr_addr);
        case (wr_op)
            2'd0:    return wr_src;
            2'd1:    return o | wr_src;
            2'd2:    return o & ~wr_src;
            default: return o;
        endcase
    endfunction

    function automatic logic [31:0] m_rd_expect();
        logic [31:0] n;
        if (wr_valid && !m_illegal() && !trap_valid && !mret_valid && rd_addr == wr_addr) begin
            n = m_new();
            if (wr_addr == 12'h300) return n & 32'h88;
            if (wr_addr == 12'h305 || wr_addr == 12'h341) return n & 32'hFFFF_FFFC;
            return n;
        end
        return m_read(rd_addr);
    endfunction

    task automatic m_reset();
        m_mie = 0; m_mpie = 0; m_mtvec = 0; m_mscratch = 0;
        m_mepc = 0; m_mcause = 0; m_cyc = 0; m_ins = 0;
    endtask

    // Apply one clock edge worth of architectural rules to the model.
    task automatic m_clock();
        longint unsigned cyc_n, ins_n;
        logic [31:0]     n;
        bit              mie_prev;
        if (rst) begin
            m_reset();
            return;
        end
        cyc_n = m_cyc + 1;
        ins_n = m_ins + (retire ? 1 : 0);
        n     = m_new();
        if (trap_valid) begin
            mie_prev = m_mie;
            m_mepc   = trap_pc & 32'hFFFF_FFFC;
            m_mcause = trap_cause;
            m_mpie   = mie_prev;
            m_mie    = 0;
        end else if (mret_valid) begin
            m_mie  = m_mpie;
            m_mpie = 1;
        end else if (wr_valid && !m_illegal() && wr_op != 2'd3) begin
            case (wr_addr)
                12'h300: begin m_mie = n[3]; m_mpie = n[7]; end
                12'h305: m_mtvec    = n & 32'hFFFF_FFFC;
                12'h340: m_mscratch = n;
                12'h341: m_mepc     = n & 32'hFFFF_FFFC;
                12'h342: m_mcause   = n;
                12'hB00: cyc_n = {m_cyc[63:32], n};
                12'hB80: cyc_n = {n, m_cyc[31:0]};
                12'hB02: ins_n = {m_ins[63:32], n};
                12'hB82: ins_n = {n, m_ins[31:0]};
                default: ;
            endcase
        end
        m_cyc = cyc_n;
        m_ins = ins_n;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic idle_inputs();
        rst = 0; wr_valid = 0; wr_addr = 0; wr_op = 0; wr_src = 0; retire = 0;
        trap_valid = 0; trap_cause = 0; trap_pc = 0; mret_valid = 0; rd_addr = 0;
    endtask

    task automatic set_wr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] src);
        wr_valid = 1; wr_addr = a; wr_op = op; wr_src = src;
    endtask

    // Called just after a negedge with inputs applied: check combinational outputs,
    // take the clock edge, update the model, then check registered outputs.
    task automatic step();
        #1;
        chk("wr_old", wr_old, m_read(wr_addr));
        chk("wr_illegal", {31'b0, wr_illegal}, {31'b0, m_illegal()});
        chk("rd_value", rd_value, m_rd_expect());
        @(posedge clk);
        m_clock();
        @(negedge clk);
        chk("mtvec_o", mtvec_o, m_mtvec);
        chk("mepc_o", mepc_o, m_mepc);
        chk("mie_o", {31'b0, mie_o}, {31'b0, m_mie});
        idle_inputs();
    endtask

    task automatic peek(input string tag, input logic [11:0] a, input logic [31:0] exp);
        rd_addr = a;
        #1;
        chk(tag, rd_value, exp);
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        @(negedge clk);
        m_reset();
        rst = 1;
        step();

        // 1: five idle cycles after reset
        repeat (5) step();
        peek("t1_mcycle", 12'hB00, 32'd5);
        peek("t1_mstatus", 12'h300, 32'h0);
        chk("t1_mtvec", mtvec_o, 32'h0);

        // 2: mtvec write with low bits forced clear
        set_wr(12'h305, 2'd0, 32'h8000_0103);
        #1 chk("t2_wr_old", wr_old, 32'h0);
        step();
        chk("t2_mtvec", mtvec_o, 32'h8000_0100);

        // 3: mscratch RW / RS / RC
        set_wr(12'h340, 2'd0, 32'h0000_F0F0);
        step();
        set_wr(12'h340, 2'd1, 32'h0000_000F);
        #1 chk("t3_rs_old", wr_old, 32'h0000_F0F0);
        step();
        peek("t3_rs_val", 12'h340, 32'h0000_F0FF);
        set_wr(12'h340, 2'd2, 32'h0000_00F0);
        #1 chk("t3_rc_old", wr_old, 32'h0000_F0FF);
        step();
        peek("t3_rc_val", 12'h340, 32'h0000_F00F);

        // 4: mcycle low-half write carries into the upper half
        set_wr(12'hB80, 2'd0, 32'h0);
        step();
        set_wr(12'hB00, 2'd0, 32'hFFFF_FFFF);
        step();
        step();
        peek("t4_mcycleh", 12'hB80, 32'h1);
        peek("t4_mcycle", 12'hB00, 32'h0);
        set_wr(12'hB02, 2'd0, 32'h10);
        retire = 1;
        step();
        peek("t4_minstret", 12'hB02, 32'h10);

        // 5: trap beats coincident CSR write, then mret
        set_wr(12'h300, 2'd0, 32'h8);
        step();
        chk("t5_mie_set", {31'b0, mie_o}, 32'h1);
        set_wr(12'h340, 2'd0, 32'h55);
        trap_valid = 1; trap_cause = 32'h8000_0007; trap_pc = 32'h1236;
        step();
        chk("t5_mepc", mepc_o, 32'h1234);
        chk("t5_mie", {31'b0, mie_o}, 32'h0);
        peek("t5_mstatus", 12'h300, 32'h80);
        peek("t5_mscratch", 12'h340, 32'h0000_F00F);
        peek("t5_mcause", 12'h342, 32'h8000_0007);
        mret_valid = 1;
        step();
        chk("t5_mret_mie", {31'b0, mie_o}, 32'h1);
        peek("t5_mret_mstatus", 12'h300, 32'h88);

        // 6: read-only write is illegal; same-cycle bypass
        set_wr(12'hC00, 2'd0, 32'h1234_5678);
        #1 chk("t6_illegal", {31'b0, wr_illegal}, 32'h1);
        step();
        set_wr(12'h340, 2'd0, 32'h99);
        rd_addr = 12'h340;
        #1 chk("t6_bypass", rd_value, 32'h99);
        step();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic [11:0] addrs [16] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342,
                                        12'hB00, 12'hB80, 12'hB02, 12'hB82,
                                        12'hC00, 12'hC80, 12'hC02, 12'hC82,
                                        12'h301, 12'h7C0, 12'hF11};
            if ($urandom_range(0, 99) == 0) begin
                rst = 1;
            end else begin
                wr_valid   = $urandom_range(0, 1) == 1;
                wr_addr    = addrs[$urandom_range(0, 15)];
                wr_op      = 2'($urandom_range(0, 3));
                wr_src     = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
                retire     = $urandom_range(0, 1) == 1;
                trap_valid = $urandom_range(0, 15) == 0;
                trap_cause = $urandom;
                trap_pc    = $urandom;
                mret_valid = $urandom_range(0, 15) == 0;
                rd_addr    = ($urandom_range(0, 3) == 0) ? wr_addr : addrs[$urandom_range(0, 15)];
            end
            step();
        end

        $display("%0d/%0d checks passed", pass_cnt, checks);
        $finish;
    end

endmodule
